s298_bist_ctrl: RTL and testbench



---
 rtl/s298_bist_pkg.sv | 49 ++++
 rtl/s298_bist_misr.sv | 33 +++
 rtl/s298_bist_ctrl.sv | 146 ++++++++++++++
 tb/tb_s298_bist_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s298_bist_pkg.sv
// -----------------------------------------------------------------------------
// s298_bist_pkg
// Shared definitions for the s298 BIST sequencer:
//   - FSM state encoding (IDLE, INIT, RUN, FLUSH, DONE)
//   - LFSR tap mask and next-state helper (Fibonacci, taps 16,14,13,11)
//   - MISR feedback polynomial and next-state helper
//   - bit positions of the core outputs inside DUT_OUT
// Optional feature macro used by the top: S298_BIST_G0_RAND_EN.
// -----------------------------------------------------------------------------
package s298_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Feedback taps expressed on the shift-toward-bit-0 register:
    // new bit 15 = l[0] ^ l[2] ^ l[3] ^ l[5]
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    localparam logic [15:0] MISR_POLY = 16'hB400;

    // DUT_OUT packing: {G133, G132, G118, G117, G67, G66}
    localparam int unsigned OUT_WIDTH = 6;
    localparam int unsigned OUT_G66   = 0;
    localparam int unsigned OUT_G67   = 1;
    localparam int unsigned OUT_G117  = 2;
    localparam int unsigned OUT_G118  = 3;
    localparam int unsigned OUT_G132  = 4;
    localparam int unsigned OUT_G133  = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAP_MASK), l[15:1]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m,
                                              input logic [OUT_WIDTH-1:0] d);
        logic [15:0] r;
        r = {m[0], m[15:1]} ^ {{(16-OUT_WIDTH){1'b0}}, d};
        if (m[0]) begin
            r = r ^ MISR_POLY;
        end
        return r;
    endfunction

endpackage

// File: rtl/s298_bist_misr.sv
// -----------------------------------------------------------------------------
// s298_bist_misr
// 16-bit multiple-input signature register compacting the six s298 outputs.
// Ports:
//   CK   in   clock, rising edge
//   RN   in   asynchronous active-low reset (signature -> 0)
//   clr  in   synchronous clear (wins over en)
//   en   in   capture din into the signature this cycle
//   din  in   6-bit core response {G133,G132,G118,G117,G67,G66}
//   sig  out  current signature (registered)
// -----------------------------------------------------------------------------
module s298_bist_misr
    import s298_bist_pkg::*;
(
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 clr,
    input  logic                 en,
    input  logic [OUT_WIDTH-1:0] din,
    output logic [15:0]          sig
);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule

// File: rtl/s298_bist_ctrl.sv
// -----------------------------------------------------------------------------
// s298_bist_ctrl
// BIST sequencer for the s298 benchmark core. One START gives one run:
// INIT (G0 held high for INIT_CYCLES), RUN (NUM_PATTERNS LFSR patterns on
// G1/G2), FLUSH (one extra MISR capture), then DONE with the signature
// compared against GOLDEN.
// Optional feature: define S298_BIST_G0_RAND_EN to pulse G0 during RUN with
// lfsr[2] & lfsr[7] & lfsr[12]; undefined keeps G0 low through RUN.
// Parameters:
//   NUM_PATTERNS  RUN length in cycles (1..65535)
//   INIT_CYCLES   G0-high cycles before RUN (1..15)
//   LFSR_SEED     LFSR load value on START (0 is replaced by 16'h0001)
// Ports:
//   CK         in   clock, rising edge
//   RN         in   asynchronous active-low reset
//   START      in   start request, honoured in IDLE or DONE only
//   GOLDEN     in   expected signature
//   DUT_OUT    in   core outputs {G133,G132,G118,G117,G67,G66}
//   DUT_G0     out  core G0 (sync clear)
//   DUT_G1     out  core G1
//   DUT_G2     out  core G2
//   BUSY       out  high in INIT, RUN and FLUSH
//   DONE       out  high in DONE
//   PASS       out  SIGNATURE == GOLDEN while DONE, else 0
//   SIGNATURE  out  MISR contents
// -----------------------------------------------------------------------------
module s298_bist_ctrl
    import s298_bist_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 256,
    parameter int unsigned INIT_CYCLES  = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 START,
    input  logic [15:0]          GOLDEN,
    input  logic [OUT_WIDTH-1:0] DUT_OUT,
    output logic                 DUT_G0,
    output logic                 DUT_G1,
    output logic                 DUT_G2,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [15:0]          SIGNATURE
);

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST_PAT  = 16'(NUM_PATTERNS - 1);
    localparam logic [3:0]  LAST_INIT = 4'(INIT_CYCLES - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] pat_cnt;
    logic [3:0]  init_cnt;
    logic        g0_run;
    logic        misr_clr;
    logic        misr_en;

`ifdef S298_BIST_G0_RAND_EN
    assign g0_run = lfsr[2] & lfsr[7] & lfsr[12];
`else
    assign g0_run = 1'b0;
`endif

    assign misr_clr = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign misr_en  = (state == ST_RUN) || (state == ST_FLUSH);

    // The DUT input registers are loaded from the LFSR on the edge that
    // enters each RUN cycle, and the LFSR steps on that same edge; so while
    // pattern k is on G1/G2 the LFSR already holds pattern k+1.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            lfsr     <= '0;
            pat_cnt  <= '0;
            init_cnt <= '0;
            DUT_G0   <= 1'b1;
            DUT_G1   <= 1'b0;
            DUT_G2   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state    <= ST_INIT;
                        lfsr     <= SEED_EFF;
                        pat_cnt  <= '0;
                        init_cnt <= '0;
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (init_cnt == LAST_INIT) begin
                        state  <= ST_RUN;
                        DUT_G0 <= g0_run;
                        DUT_G1 <= lfsr[0];
                        DUT_G2 <= lfsr[1];
                        lfsr   <= lfsr_next(lfsr);
                    end else begin
                        init_cnt <= init_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (pat_cnt == LAST_PAT) begin
                        // DUT inputs and LFSR hold through FLUSH
                        state <= ST_FLUSH;
                    end else begin
                        pat_cnt <= pat_cnt + 16'd1;
                        DUT_G0  <= g0_run;
                        DUT_G1  <= lfsr[0];
                        DUT_G2  <= lfsr[1];
                        lfsr    <= lfsr_next(lfsr);
                    end
                end
                ST_FLUSH: begin
                    state  <= ST_DONE;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                    DUT_G0 <= 1'b1;
                    DUT_G1 <= 1'b0;
                    DUT_G2 <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

    s298_bist_misr u_misr (
        .CK  (CK),
        .RN  (RN),
        .clr (misr_clr),
        .en  (misr_en),
        .din (DUT_OUT),
        .sig (SIGNATURE)
    );

    assign PASS = DONE && (SIGNATURE == GOLDEN);

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s298_bist_ctrl
// Directed bench for s298_bist_ctrl. Three instances cover the parameter
// corners: a short run (4 patterns), the default 256-pattern run, and a
// zero seed. Expected G0/G1/G2 and signatures come from a small LFSR/MISR
// model kept here. Honours S298_BIST_G0_RAND_EN for the G0 expectation.
// -----------------------------------------------------------------------------
module tb_s298_bist_ctrl;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start_v [3];
    logic [5:0]  out_v   [3];
    logic [15:0] gold_v  [3];
    logic        g0_v    [3];
    logic        g1_v    [3];
    logic        g2_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        pass_v  [3];
    logic [15:0] sig_v   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CK = ~CK;

    s298_bist_ctrl #(.NUM_PATTERNS(4), .INIT_CYCLES(2), .LFSR_SEED(16'hACE1)) dut_a (
        .CK(CK), .RN(RN), .START(start_v[0]), .GOLDEN(gold_v[0]), .DUT_OUT(out_v[0]),
        .DUT_G0(g0_v[0]), .DUT_G1(g1_v[0]), .DUT_G2(g2_v[0]), .BUSY(busy_v[0]),
        .DONE(done_v[0]), .PASS(pass_v[0]), .SIGNATURE(sig_v[0]));

    s298_bist_ctrl #(.NUM_PATTERNS(256), .INIT_CYCLES(2), .LFSR_SEED(16'hACE1)) dut_b (
        .CK(CK), .RN(RN), .START(start_v[1]), .GOLDEN(gold_v[1]), .DUT_OUT(out_v[1]),
        .DUT_G0(g0_v[1]), .DUT_G1(g1_v[1]), .DUT_G2(g2_v[1]), .BUSY(busy_v[1]),
        .DONE(done_v[1]), .PASS(pass_v[1]), .SIGNATURE(sig_v[1]));

    s298_bist_ctrl #(.NUM_PATTERNS(4), .INIT_CYCLES(1), .LFSR_SEED(16'h0000)) dut_c (
        .CK(CK), .RN(RN), .START(start_v[2]), .GOLDEN(gold_v[2]), .DUT_OUT(out_v[2]),
        .DUT_G0(g0_v[2]), .DUT_G1(g1_v[2]), .DUT_G2(g2_v[2]), .BUSY(busy_v[2]),
        .DONE(done_v[2]), .PASS(pass_v[2]), .SIGNATURE(sig_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    function automatic logic [15:0] m_lfsr(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [5:0] d);
        logic [15:0] r;
        r = {m[0], m[15:1]} ^ {10'b0, d};
        if (m[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic m_g0(input logic [15:0] l);
`ifdef S298_BIST_G0_RAND_EN
        return l[2] & l[7] & l[12];
`else
        return 1'b0;
`endif
    endfunction

    // Stand-in core response: mode 0 ties DUT_OUT low, mode 1 mixes the
    // cycle index with the pattern on the core inputs.
    function automatic logic [5:0] m_resp(input int mode, input int k, input logic [15:0] l);
        logic [5:0] r;
        r = (mode == 0) ? 6'h00 : (6'(k * 7 + 13) ^ l[5:0]);
        return r;
    endfunction

    // One complete run on instance idx, checking every cycle of it.
    task automatic run_seq(input int idx, input int n, input int init, input logic [15:0] seed,
                           input int mode, input int flip_k, output logic [15:0] sig_exp);
        logic [15:0] l, lprev, m;
        logic [5:0]  d;
        l     = (seed == 16'h0000) ? 16'h0001 : seed;
        lprev = l;
        m     = '0;
        start_v[idx] = 1'b1;
        out_v[idx]   = 6'h3F;   // must not be captured during INIT
        tick();
        start_v[idx] = 1'b0;
        for (int c = 0; c < init; c++) begin
            chk("init_busy", 32'(busy_v[idx]), 32'd1);
            chk("init_done", 32'(done_v[idx]), 32'd0);
            chk("init_g0",   32'(g0_v[idx]),   32'd1);
            chk("init_g1g2", 32'({g2_v[idx], g1_v[idx]}), 32'd0);
            tick();
        end
        for (int k = 0; k < n; k++) begin
            chk("run_busy", 32'(busy_v[idx]), 32'd1);
            chk("run_g0",   32'(g0_v[idx]),   32'(m_g0(l)));
            chk("run_g1g2", 32'({g2_v[idx], g1_v[idx]}), 32'(l[1:0]));
            chk("run_pass", 32'(pass_v[idx]), 32'd0);
            d = m_resp(mode, k, l);
            if (k == flip_k) d = d ^ 6'h08;
            out_v[idx] = d;
            m     = m_misr(m, d);
            lprev = l;
            l     = m_lfsr(l);
            tick();
        end
        chk("flush_busy", 32'(busy_v[idx]), 32'd1);
        chk("flush_done", 32'(done_v[idx]), 32'd0);
        chk("flush_g0",   32'(g0_v[idx]),   32'(m_g0(lprev)));
        chk("flush_g1g2", 32'({g2_v[idx], g1_v[idx]}), 32'(lprev[1:0]));
        d = m_resp(mode, n, lprev);
        out_v[idx] = d;
        m = m_misr(m, d);
        tick();
        chk("done_done", 32'(done_v[idx]), 32'd1);
        chk("done_busy", 32'(busy_v[idx]), 32'd0);
        chk("done_g0",   32'(g0_v[idx]),   32'd1);
        chk("done_g1g2", 32'({g2_v[idx], g1_v[idx]}), 32'd0);
        chk("done_sig",  32'(sig_v[idx]),  32'(m));
        out_v[idx] = 6'h00;
        sig_exp = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s0, s1, s2;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            out_v[i]   = 6'h00;
            gold_v[i]  = 16'h0000;
        end
        RN = 1'b0;
        tick();
        tick();

        // Reset state; GOLDEN equals SIGNATURE here but PASS must stay low
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
            chk("rst_done", 32'(done_v[i]), 32'd0);
            chk("rst_pass", 32'(pass_v[i]), 32'd0);
            chk("rst_sig",  32'(sig_v[i]),  32'd0);
            chk("rst_g0",   32'(g0_v[i]),   32'd1);
            chk("rst_g1g2", 32'({g2_v[i], g1_v[i]}), 32'd0);
        end
        RN = 1'b1;
        tick();

        // Short run: 2 INIT + 4 RUN + 1 FLUSH, DUT_OUT tied low, golden 0
        run_seq(0, 4, 2, 16'hACE1, 0, -1, s0);
        chk("zero_sig", 32'(sig_v[0]), 32'h0);
        chk("zero_pass", 32'(pass_v[0]), 32'd1);
        gold_v[0] = 16'h1234;
        #1;
        chk("wrong_gold_pass", 32'(pass_v[0]), 32'd0);

        // Non-trivial response, then the same with one flipped bit (restart from DONE)
        run_seq(0, 4, 2, 16'hACE1, 1, -1, s1);
        gold_v[0] = s1;
        #1;
        chk("a_gold_pass", 32'(pass_v[0]), 32'd1);
        run_seq(0, 4, 2, 16'hACE1, 1, 2, s2);
        chk("a_flip_differs", 32'(sig_v[0] != s1), 32'd1);
        chk("a_flip_pass", 32'(pass_v[0]), 32'd0);

        // Full 256-pattern runs: zero response, then response with a flip at k=50
        run_seq(1, 256, 2, 16'hACE1, 0, -1, s0);
        chk("b_zero_sig", 32'(sig_v[1]), 32'h0);
        run_seq(1, 256, 2, 16'hACE1, 1, -1, s1);
        gold_v[1] = s1;
        #1;
        chk("b_gold_pass", 32'(pass_v[1]), 32'd1);
        run_seq(1, 256, 2, 16'hACE1, 1, 50, s2);
        chk("b_flip_differs", 32'(sig_v[1] != s1), 32'd1);
        chk("b_flip_pass", 32'(pass_v[1]), 32'd0);

        // Zero seed: first pattern must come from 16'h0001
        tick();
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        tick();   // one INIT cycle
        chk("seed0_first_g1g2", 32'({g2_v[2], g1_v[2]}), 32'h1);
        repeat (8) tick();
        run_seq(2, 4, 1, 16'h0000, 1, -1, s0);

        // Reset pulsed in the middle of RUN (k=100)
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        repeat (2 + 100) tick();
        chk("mid_busy_before", 32'(busy_v[1]), 32'd1);
        RN = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_v[1]), 32'd0);
        chk("mid_rst_done", 32'(done_v[1]), 32'd0);
        chk("mid_rst_sig",  32'(sig_v[1]),  32'd0);
        chk("mid_rst_g0",   32'(g0_v[1]),   32'd1);
        tick();
        RN = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy_v[1]), 32'd0);
        run_seq(1, 256, 2, 16'hACE1, 1, -1, s1);
        chk("post_rst_same_sig", 32'(sig_v[1]), 32'(s1));

        // START held high: no restart while BUSY, restart right after DONE
        gold_v[0] = 16'h0000;
        start_v[0] = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            chk("held_busy", 32'(busy_v[0]), 32'd1);
            chk("held_done", 32'(done_v[0]), 32'd0);
            tick();
        end
        chk("held_done_rise", 32'(done_v[0]), 32'd1);
        chk("held_busy_low",  32'(busy_v[0]), 32'd0);
        chk("held_pass",      32'(pass_v[0]), 32'd1);
        tick();
        chk("held_restart_busy", 32'(busy_v[0]), 32'd1);
        chk("held_restart_done", 32'(done_v[0]), 32'd0);
        start_v[0] = 1'b0;
        for (int c = 0; c < 20 && done_v[0] !== 1'b1; c++) tick();
        chk("held_second_done", 32'(done_v[0]), 32'd1);
        chk("held_second_sig",  32'(sig_v[0]),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
